// File: rtl/imem_dmem_port_arbiter_pkg.sv
// mem_arb_pkg: FSM states, owner encoding and counter width shared by the IF/DM memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;
    localparam int CNT_W = 4;
endpackage

// File: rtl/imem_dmem_port_arbiter_if.sv
// imem_dmem_port_arbiter_if: fetch port, data port and memory-side bus of the unified memory arbiter.
interface imem_dmem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          if_req, if_valid, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid, dm_stall;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_port_arbiter_lat_timer.sv
// arb_lat_timer: loadable down-counter that stops at zero and flags done while at zero.
module arb_lat_timer
    import mem_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
    assign done = cnt_q == '0;
endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter: shares one fixed-latency memory between fetch (IF) and data (DM) ports, DM first.
// Define ARB_FETCH_GUARD_EN to force an IF grant after STARVE_MAX consecutive DM grants that kept IF waiting.
module imem_dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic clock,
    input logic reset,
    imem_dmem_port_arbiter_if.slave bus
);
    state_t        state_q, state_d;
    logic          owner_q, owner_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic          arb, force_if, grant_dm, grant_if, lat_done;

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
        $error("imem_dmem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
    end

    assign arb      = state_q == IDLE || state_q == RESP;
    assign grant_dm = arb && bus.dm_req && !force_if;
    assign grant_if = arb && bus.if_req && !grant_dm;

`ifdef ARB_FETCH_GUARD_EN
    // Counts DM grants that left a pending fetch behind; hitting the limit hands the next grant to IF.
    logic [CNT_W-1:0] starve_q, starve_d;
    assign force_if = bus.if_req && starve_q == CNT_W'(STARVE_MAX);
    always_comb starve_d = (grant_dm && bus.if_req) ? starve_q + CNT_W'(1) : (grant_dm || grant_if) ? '0 : starve_q;
    always_ff @(posedge clock) starve_q <= reset ? '0 : starve_d;
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = (grant_dm || grant_if) ? ISSUE : IDLE;
                if (grant_dm || grant_if) begin
                    owner_d = grant_dm ? OWN_DM : OWN_IF;
                    we_d    = grant_dm && bus.dm_we;
                    addr_d  = grant_dm ? bus.dm_addr : bus.if_addr;
                    wdata_d = bus.dm_wdata;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (lat_done) begin
                state_d    = RESP;
                if_rdata_d = (owner_q == OWN_IF) ? bus.mem_rdata : if_rdata_q;
                dm_rdata_d = (owner_q == OWN_DM && !we_q) ? bus.mem_rdata : dm_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    arb_lat_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q == ISSUE),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .done     (lat_done)
    );

    assign bus.mem_en    = state_q == ISSUE;
    assign bus.mem_we    = state_q == ISSUE && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_valid  = state_q == RESP && owner_q == OWN_IF;
    assign bus.dm_valid  = state_q == RESP && owner_q == OWN_DM;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_stall  = bus.if_req && !bus.if_valid;
    assign bus.dm_stall  = bus.dm_req && !bus.dm_valid;
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb_imem_dmem_port_arbiter: directed vector table on a MEM_LAT=1 arbiter plus latency, reset and fairness sequences.
module tb_imem_dmem_port_arbiter;
    localparam logic [31:0] I = 32'h00500093, J = 32'h00A00113, D = 32'hDEADBEEF, S = 32'h12345678;

    typedef struct {
        logic [31:0] if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata;
        logic [31:0] mem_en, mem_we, mem_addr, mem_wdata;
        logic [31:0] if_valid, dm_valid, if_stall, dm_stall, if_rdata, dm_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int n_tests = 0, n_fail = 0, en_cnt_a = 0, en_cnt_b = 0;
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] rd_a;
    logic [31:0] pipe_b [0:2];
    vec_t tbl [19];

    always #5 clk = ~clk;

    imem_dmem_port_arbiter_if #(.AW(32), .DW(32)) a_if ();
    imem_dmem_port_arbiter_if #(.AW(32), .DW(32)) b_if ();

    imem_dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clock(clk), .reset(rst_a), .bus(a_if));
    imem_dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clock(clk), .reset(rst_b), .bus(b_if));

    assign a_if.mem_rdata = rd_a;
    assign b_if.mem_rdata = pipe_b[2];

    // Memory models: data is only meaningful exactly MEM_LAT cycles after mem_en, poison otherwise.
    always @(posedge clk) begin
        if (rst_a) begin
            mem_a[0]  <= I;
            mem_a[2]  <= J;
            mem_a[64] <= D;
        end else if (a_if.mem_en && a_if.mem_we)
            mem_a[a_if.mem_addr[9:2]] <= a_if.mem_wdata;
        rd_a <= a_if.mem_en ? mem_a[a_if.mem_addr[9:2]] : 32'hBAD0BAD0;
        if (a_if.mem_en) en_cnt_a <= en_cnt_a + 1;
    end

    always @(posedge clk) begin
        if (rst_b) mem_b[64] <= D;
        pipe_b[0] <= b_if.mem_en ? mem_b[b_if.mem_addr[9:2]] : 32'hBAD0BAD0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (b_if.mem_en) en_cnt_b <= en_cnt_b + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] ir, ia, dr, dw, da, wd, en, we, ma, mw, iv, dv, is, ds, ird, drd);
        v = '{ir, ia, dr, dw, da, wd, en, we, ma, mw, iv, dv, is, ds, ird, drd};
    endfunction

    task automatic wait_b(input bit dm, output int lat);
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dm ? b_if.dm_valid : b_if.if_valid) lat = c;
        end
    endtask

    initial begin
        int lat, k, vcnt;
        logic [5:0] order, exp_order;
        //            ir ia    dr dw da     wd   en we ma     mw   iv dv is ds ird drd
        tbl[0]  = v(1, 0,    0, 0, 0,     0,   1, 0, 0,     0,   0, 0, 1, 0, 0, 0);
        tbl[1]  = v(1, 0,    0, 0, 0,     0,   0, 0, 0,     0,   0, 0, 1, 0, 0, 0);
        tbl[2]  = v(1, 0,    0, 0, 0,     0,   0, 0, 0,     0,   1, 0, 0, 0, I, 0);
        tbl[3]  = v(0, 0,    0, 0, 0,     0,   0, 0, 0,     0,   0, 0, 0, 0, I, 0);
        tbl[4]  = v(1, 8,    1, 0, 'h100, 0,   1, 0, 'h100, 0,   0, 0, 1, 1, I, 0);
        tbl[5]  = v(1, 8,    1, 0, 'h100, 0,   0, 0, 0,     0,   0, 0, 1, 1, I, 0);
        tbl[6]  = v(1, 8,    1, 0, 'h100, 0,   0, 0, 0,     0,   0, 1, 1, 0, I, D);
        tbl[7]  = v(1, 8,    0, 0, 0,     0,   1, 0, 8,     0,   0, 0, 1, 0, I, D);
        tbl[8]  = v(1, 8,    0, 0, 0,     0,   0, 0, 0,     0,   0, 0, 1, 0, I, D);
        tbl[9]  = v(1, 8,    0, 0, 0,     0,   0, 0, 0,     0,   1, 0, 0, 0, J, D);
        tbl[10] = v(0, 0,    0, 0, 0,     0,   0, 0, 0,     0,   0, 0, 0, 0, J, D);
        tbl[11] = v(0, 0,    1, 1, 'h104, S,   1, 1, 'h104, S,   0, 0, 0, 1, J, D);
        tbl[12] = v(0, 0,    1, 1, 'h104, S,   0, 0, 0,     0,   0, 0, 0, 1, J, D);
        tbl[13] = v(0, 0,    1, 1, 'h104, S,   0, 0, 0,     0,   0, 1, 0, 0, J, D);
        tbl[14] = v(0, 0,    0, 0, 0,     0,   0, 0, 0,     0,   0, 0, 0, 0, J, D);
        tbl[15] = v(0, 0,    1, 0, 'h104, 0,   1, 0, 'h104, 0,   0, 0, 0, 1, J, D);
        tbl[16] = v(0, 0,    1, 0, 'h104, 0,   0, 0, 0,     0,   0, 0, 0, 1, J, D);
        tbl[17] = v(0, 0,    1, 0, 'h104, 0,   0, 0, 0,     0,   0, 1, 0, 0, J, S);
        tbl[18] = v(0, 0,    0, 0, 0,     0,   0, 0, 0,     0,   0, 0, 0, 0, J, S);

        {a_if.if_req, a_if.dm_req, a_if.dm_we} = 3'b000;
        {b_if.if_req, b_if.dm_req, b_if.dm_we} = 3'b000;
        a_if.if_addr = '0; a_if.dm_addr = '0; a_if.dm_wdata = '0;
        b_if.if_addr = '0; b_if.dm_addr = '0; b_if.dm_wdata = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a ctl", {a_if.mem_en, a_if.mem_we, a_if.if_valid, a_if.dm_valid, a_if.if_stall, a_if.dm_stall}, 0);
        chk("rst_a addr/wdata", a_if.mem_addr | a_if.mem_wdata, 0);
        chk("rst_a rdata", a_if.if_rdata | a_if.dm_rdata, 0);
        chk("rst_b ctl", {b_if.mem_en, b_if.mem_we, b_if.if_valid, b_if.dm_valid, b_if.if_stall, b_if.dm_stall}, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 19; i++) begin
            a_if.if_req   = tbl[i].if_req[0];
            a_if.if_addr  = tbl[i].if_addr;
            a_if.dm_req   = tbl[i].dm_req[0];
            a_if.dm_we    = tbl[i].dm_we[0];
            a_if.dm_addr  = tbl[i].dm_addr;
            a_if.dm_wdata = tbl[i].dm_wdata;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("r%0d mem_en", i), a_if.mem_en, tbl[i].mem_en);
            chk($sformatf("r%0d mem_we", i), a_if.mem_we, tbl[i].mem_we);
            if (tbl[i].mem_en[0]) begin
                chk($sformatf("r%0d mem_addr", i), a_if.mem_addr, tbl[i].mem_addr);
                chk($sformatf("r%0d mem_wdata", i), a_if.mem_wdata, tbl[i].mem_wdata);
            end
            chk($sformatf("r%0d if_valid", i), a_if.if_valid, tbl[i].if_valid);
            chk($sformatf("r%0d dm_valid", i), a_if.dm_valid, tbl[i].dm_valid);
            chk($sformatf("r%0d if_stall", i), a_if.if_stall, tbl[i].if_stall);
            chk($sformatf("r%0d dm_stall", i), a_if.dm_stall, tbl[i].dm_stall);
            chk($sformatf("r%0d if_rdata", i), a_if.if_rdata, tbl[i].if_rdata);
            chk($sformatf("r%0d dm_rdata", i), a_if.dm_rdata, tbl[i].dm_rdata);
        end
        chk("mem_en pulses A", en_cnt_a, 5);

        // MEM_LAT=3 load: valid MEM_LAT+2 cycles after the request edge, single pulse
        b_if.dm_req  = 1'b1;
        b_if.dm_addr = 32'h100;
        wait_b(1'b1, lat);
        b_if.dm_req = 1'b0;
        chk("lat3 latency", lat, 5);
        chk("lat3 dm_rdata", b_if.dm_rdata, D);
        @(posedge clk);
        @(negedge clk);
        chk("lat3 single pulse", {b_if.dm_valid, b_if.mem_en}, 0);
        chk("lat3 mem_en pulses", en_cnt_b, 1);

        // Reset during WAIT aborts the load without a valid pulse
        b_if.dm_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        b_if.dm_req = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wait rst ctl", {b_if.mem_en, b_if.mem_we, b_if.if_valid, b_if.dm_valid, b_if.if_stall, b_if.dm_stall}, 0);
        chk("wait rst rdata", b_if.dm_rdata | b_if.if_rdata | b_if.mem_addr, 0);
        rst_b = 1'b0;
        vcnt = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            vcnt += int'(b_if.dm_valid) + int'(b_if.if_valid);
        end
        chk("wait rst no valid", vcnt, 0);
        b_if.if_req  = 1'b1;
        b_if.if_addr = 32'h100;
        wait_b(1'b0, lat);
        b_if.if_req = 1'b0;
        chk("post rst latency", lat, 5);
        chk("post rst if_rdata", b_if.if_rdata, D);

        // Both ports held: grant order with and without the fetch guard
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        a_if.if_req  = 1'b1;
        a_if.if_addr = 32'h0;
        a_if.dm_req  = 1'b1;
        a_if.dm_we   = 1'b0;
        a_if.dm_addr = 32'h100;
        order = '0;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_if.mem_en) begin
                order[k] = a_if.mem_addr == 32'h100;
                k++;
            end
        end
`ifdef ARB_FETCH_GUARD_EN
        exp_order = 6'b101111;
`else
        exp_order = 6'b111111;
`endif
        chk("grant count", k, 6);
        chk("grant order", order, exp_order);
        a_if.if_req = 1'b0;
        a_if.dm_req = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
